mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for a 256-word data memory with byte/half/word accesses.
// Define MEM_ACCESS_SUBWORD_EN for sub-word loads and read-modify-write stores.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] ld_word;
  logic [31:0] st_word;

`ifdef MEM_ACCESS_SUBWORD_EN
  localparam logic SUB_OK = 1'b1;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_rdata_i[7:0];
    unique case (addr_q[1:0])
      2'd0: lane_b = mem_rdata_i[7:0];
      2'd1: lane_b = mem_rdata_i[15:8];
      2'd2: lane_b = mem_rdata_i[23:16];
      2'd3: lane_b = mem_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata_i[31:16]
                       : mem_rdata_i[15:0];
    ld_word = mem_rdata_i;
    st_word = mem_rdata_i;
    if (size_q == 2'b00) begin
      ld_word = signed_q ? {{24{lane_b[7]}}, lane_b}
                         : {24'h0, lane_b};
      unique case (addr_q[1:0])
        2'd0: st_word[7:0]   = wword_q[7:0];
        2'd1: st_word[15:8]  = wword_q[7:0];
        2'd2: st_word[23:16] = wword_q[7:0];
        2'd3: st_word[31:24] = wword_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      ld_word = signed_q ? {{16{lane_h[15]}}, lane_h}
                         : {16'h0, lane_h};
      if (addr_q[1]) st_word[31:16] = wword_q[15:0];
      else           st_word[15:0]  = wword_q[15:0];
    end
  end
`else
  localparam logic SUB_OK = 1'b0;
  logic unused_sub;
  assign unused_sub = ^{size_q, signed_q, addr_q[1:0]};
  assign ld_word = mem_rdata_i;
  assign st_word = mem_rdata_i;
`endif

  // The 1 KiB window makes any address bit above 9 out of range.
  always_comb begin
    req_err = (req_addr_i[31:10] != 22'h0);
    unique case (req_size_i)
      2'b00: req_err = req_err | ~SUB_OK;
      2'b01: req_err = req_err | ~SUB_OK | req_addr_i[0];
      2'b10: req_err = req_err | (req_addr_i[1:0] != 2'b00);
      2'b11: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wword_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid_i) begin
          write_q  <= req_write_i;
          size_q   <= req_size_i;
          signed_q <= req_signed_i;
          addr_q   <= req_addr_i;
          wword_q  <= req_wdata_i;
          rdata_q  <= '0;
          err_q    <= req_err;
          if (req_err)
            state_q <= RESP;
          else if (req_write_i && req_size_i == 2'b10)
            state_q <= WRITE;
          else
            state_q <= READ;
        end
        READ: begin
          if (write_q) begin
            wword_q <= st_word;
            state_q <= WRITE;
          end else begin
            rdata_q <= ld_word;
            state_q <= RESP;
          end
        end
        WRITE: state_q <= RESP;
        RESP: if (rsp_ready_i) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = rst_i & (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign mem_read_o  = (state_q == READ);
  assign mem_write_o = (state_q == WRITE);
  assign mem_addr_o  = (mem_read_o | mem_write_o)
                     ? {2'b00, addr_q[31:2]} : 32'h0;
  assign mem_wdata_o = mem_write_o ? wword_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-word memory model.
// Sub-word expectations switch on MEM_ACCESS_SUBWORD_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  logic [31:0] mem [256];
  assign mem_rdata_i = mem[mem_addr_o[7:0]];
  always @(posedge clk)
    if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;

  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] wa;
  logic [31:0] wd;
  always @(negedge clk) begin
    if (mem_read_o) rd_cnt++;
    if (mem_write_o) begin
      wr_cnt++;
      wa = mem_addr_o;
      wd = mem_wdata_o;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag,
                        input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_dat,
                        input int e_lat, input int e_rd,
                        input int e_wr, input int hold);
    int lat;
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    chk({tag, "_ready"}, {31'h0, req_ready_o}, 32'd1);
    req_write_i  = w;
    req_size_i   = sz;
    req_signed_i = sg;
    req_addr_i   = a;
    req_wdata_i  = d;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid_o && lat < 10);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_err"}, {31'h0, rsp_err_o}, {31'h0, e_err});
    chk({tag, "_data"}, rsp_rdata_o, e_dat);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_v"}, {31'h0, rsp_valid_o}, 32'd1);
      chk({tag, "_hold_d"}, rsp_rdata_o, e_dat);
      chk({tag, "_hold_rdy"}, {31'h0, req_ready_o}, 32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    chk({tag, "_drop"}, {31'h0, rsp_valid_o}, 32'd0);
    chk({tag, "_rd"}, rd_cnt, e_rd);
    chk({tag, "_wr"}, wr_cnt, e_wr);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_i        = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_size_i   = 2'b00;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    rsp_ready_i  = 1'b0;
    #3;
    chk("rst_ready", {31'h0, req_ready_o}, 32'd0);
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'd0);
    chk("rst_mrd", {31'h0, mem_read_o}, 32'd0);
    chk("rst_mwr", {31'h0, mem_write_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1 chk("rel_ready", {31'h0, req_ready_o}, 32'd1);

    do_req("st10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
           0, 32'h0, 2, 0, 1, 0);
    chk("st10_waddr", wa, 32'd4);
    chk("st10_wdata", wd, 32'hDEADBEEF);
    do_req("ld10", 0, 2'b10, 0, 32'h10, 32'h0,
           0, 32'hDEADBEEF, 2, 1, 0, 0);
    do_req("st20", 1, 2'b10, 0, 32'h20, 32'h11223344,
           0, 32'h0, 2, 0, 1, 0);

`ifdef MEM_ACCESS_SUBWORD_EN
    do_req("sb22", 1, 2'b00, 0, 32'h22, 32'h000000AA,
           0, 32'h0, 3, 1, 1, 0);
    chk("sb22_waddr", wa, 32'd8);
    chk("sb22_wdata", wd, 32'h11AA3344);
    do_req("lbs22", 0, 2'b00, 1, 32'h22, 32'h0,
           0, 32'hFFFFFFAA, 2, 1, 0, 0);
    do_req("lbu22", 0, 2'b00, 0, 32'h22, 32'h0,
           0, 32'h000000AA, 2, 1, 0, 0);
    do_req("lhs20", 0, 2'b01, 1, 32'h20, 32'h0,
           0, 32'h00003344, 2, 1, 0, 0);
    do_req("sh20", 1, 2'b01, 0, 32'h20, 32'h1234BEEF,
           0, 32'h0, 3, 1, 1, 0);
    chk("sh20_wdata", wd, 32'h11AABEEF);
    do_req("lhs20b", 0, 2'b01, 1, 32'h20, 32'h0,
           0, 32'hFFFFBEEF, 2, 1, 0, 0);
    do_req("lhu22", 0, 2'b01, 0, 32'h22, 32'h0,
           0, 32'h000011AA, 2, 1, 0, 0);
`else
    do_req("lb20", 0, 2'b00, 1, 32'h20, 32'h0,
           1, 32'h0, 1, 0, 0, 0);
    do_req("sb22", 1, 2'b00, 0, 32'h22, 32'h000000AA,
           1, 32'h0, 1, 0, 0, 0);
    do_req("ld20", 0, 2'b10, 0, 32'h20, 32'h0,
           0, 32'h11223344, 2, 1, 0, 0);
`endif

    do_req("lh21", 0, 2'b01, 0, 32'h21, 32'h0,
           1, 32'h0, 1, 0, 0, 0);
    do_req("ld400", 0, 2'b10, 0, 32'h400, 32'h0,
           1, 32'h0, 1, 0, 0, 0);
    do_req("sz11", 0, 2'b11, 0, 32'h20, 32'h0,
           1, 32'h0, 1, 0, 0, 0);
    do_req("ld12", 0, 2'b10, 0, 32'h12, 32'h0,
           1, 32'h0, 1, 0, 0, 0);
    do_req("hold", 0, 2'b10, 0, 32'h10, 32'h0,
           0, 32'hDEADBEEF, 2, 1, 0, 5);

    @(negedge clk);
    mem[12] = 32'hCAFEF00D;
    req_write_i  = 1'b1;
    req_signed_i = 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
    req_size_i  = 2'b00;
    req_addr_i  = 32'h31;
    req_wdata_i = 32'h00000055;
`else
    req_size_i  = 2'b10;
    req_addr_i  = 32'h30;
    req_wdata_i = 32'h12345678;
`endif
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    k = 0;
    while (!mem_write_o && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("rw_inwrite", {31'h0, mem_write_o}, 32'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("rw_mwr_drop", {31'h0, mem_write_o}, 32'd0);
    chk("rw_addr", mem_addr_o, 32'h0);
    chk("rw_ready", {31'h0, req_ready_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rw_mem", mem[12], 32'hCAFEF00D);
    chk("rw_valid", {31'h0, rsp_valid_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rw_rel_ready", {31'h0, req_ready_o}, 32'd1);
    chk("rw_rel_valid", {31'h0, rsp_valid_o}, 32'd0);
    do_req("ld30", 0, 2'b10, 0, 32'h30, 32'h0,
           0, 32'hCAFEF00D, 2, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
